// File: rtl/frame_cfg_pkg.sv
// Shared types and constants for the frame configuration loader: FSM states,
// header field layout and the default stream sync word.
package frame_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_DATA,
    ST_STROBE,
    ST_ERROR
  } state_t;

  localparam logic [7:0]  END_COL           = 8'hFF;
  localparam logic [31:0] DEFAULT_SYNC_WORD = 32'hFAB0_FAB1;

  localparam int COL_MSB   = 31;
  localparam int COL_LSB   = 24;
  localparam int FRAME_MSB = 23;
  localparam int FRAME_LSB = 16;
  localparam int COUNT_MSB = 15;
  localparam int COUNT_LSB = 0;

  typedef struct packed {
    logic [7:0]  col;
    logic [7:0]  frame;
    logic [15:0] count;
  } header_t;

  function automatic header_t unpack_header(input logic [31:0] word);
    header_t h;
    h.col   = word[COL_MSB:COL_LSB];
    h.frame = word[FRAME_MSB:FRAME_LSB];
    h.count = word[COUNT_MSB:COUNT_LSB];
    return h;
  endfunction

endpackage

// File: rtl/frame_config_loader_if.sv
// Word-stream write port of the configuration loader: source drives data and
// strobe, loader answers with ready.
interface frame_config_loader_if;
  logic [31:0] WriteData;
  logic        WriteStrobe;
  logic        WriteReady;

  modport master (output WriteData, output WriteStrobe, input WriteReady);
  modport slave  (input WriteData, input WriteStrobe, output WriteReady);
endinterface

// File: rtl/frame_onehot_dec.sv
// Binary-to-one-hot decoder with enable; out-of-range selects decode to zero.
module frame_onehot_dec #(
  parameter int WIDTH    = 16,
  parameter int SEL_BITS = 8
) (
  input  logic                en,
  input  logic [SEL_BITS-1:0] sel,
  output logic [WIDTH-1:0]    onehot
);

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      onehot[i] = en && (sel == SEL_BITS'(i));
    end
  end

endmodule

// File: rtl/frame_config_loader.sv
// Parses the sync/header/data configuration stream and drives FrameData,
// one-hot ColSelect and single-cycle FrameStrobe pulses into the column latches.
module frame_config_loader
  import frame_cfg_pkg::*;
#(
  parameter int          FRAME_BITS     = 32,
  parameter int          FRAMES_PER_COL = 20,
  parameter int          NUM_COLS       = 16,
  parameter logic [31:0] SYNC_WORD      = DEFAULT_SYNC_WORD
) (
  input  logic                      CLK,
  input  logic                      resetn,
  frame_config_loader_if.slave      wr,
  output logic [FRAME_BITS-1:0]     FrameData,
  output logic [NUM_COLS-1:0]       ColSelect,
  output logic [FRAMES_PER_COL-1:0] FrameStrobe,
  output logic                      Configured,
  output logic                      Error
);

  state_t      state_q, state_d;
  logic [7:0]  frame_ptr;
  logic [15:0] remaining;

  header_t     hdr;
  logic [16:0] hdr_end_frame;
  logic        hdr_bad;
  logic        write_ready;
  logic        accept;
  logic        is_sync;

  logic        hdr_load;
  logic        ptr_load;
  logic        hdr_end;
  logic        hdr_err;
  logic        data_load;
  logic        err_clr;

  logic [NUM_COLS-1:0]       col_onehot;
  logic [FRAMES_PER_COL-1:0] strobe_onehot;

  assign hdr           = unpack_header(wr.WriteData);
  // Widened sum so a large count cannot wrap past the frame limit.
  assign hdr_end_frame = {9'd0, hdr.frame} + {1'b0, hdr.count};
  assign hdr_bad       = (32'(hdr.col) >= NUM_COLS) ||
                         (32'(hdr_end_frame) > FRAMES_PER_COL);

  assign write_ready    = (state_q != ST_STROBE);
  assign wr.WriteReady  = write_ready;
  assign accept         = wr.WriteStrobe && write_ready;
  assign is_sync        = (wr.WriteData == SYNC_WORD);

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    state_d   = state_q;
    hdr_load  = 1'b0;
    ptr_load  = 1'b0;
    hdr_end   = 1'b0;
    hdr_err   = 1'b0;
    data_load = 1'b0;
    err_clr   = 1'b0;

    case (state_q)
      ST_IDLE, ST_ERROR: begin
        if (accept && is_sync) begin
          state_d = ST_HEADER;
          err_clr = 1'b1;
        end
      end

      ST_HEADER: begin
        if (accept) begin
          if (hdr.col == END_COL) begin
            hdr_end = 1'b1;
            state_d = ST_IDLE;
          end else if (hdr_bad) begin
            hdr_err = 1'b1;
            state_d = ST_ERROR;
          end else begin
            hdr_load = 1'b1;
            if (hdr.count != 16'd0) begin
              ptr_load = 1'b1;
              state_d  = ST_DATA;
            end
          end
        end
      end

      ST_DATA: begin
        if (accept) begin
          data_load = 1'b1;
          state_d   = ST_STROBE;
        end
      end

      ST_STROBE: begin
        state_d = (remaining == 16'd1) ? ST_HEADER : ST_DATA;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  frame_onehot_dec #(
    .WIDTH   (NUM_COLS),
    .SEL_BITS(8)
  ) u_col_dec (
    .en    (hdr_load),
    .sel   (hdr.col),
    .onehot(col_onehot)
  );

  frame_onehot_dec #(
    .WIDTH   (FRAMES_PER_COL),
    .SEL_BITS(8)
  ) u_strobe_dec (
    .en    (state_q == ST_STROBE),
    .sel   (frame_ptr),
    .onehot(strobe_onehot)
  );

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignment so all registers
    // sample their inputs from the same pre-edge values.
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge CLK) begin
    if (!resetn) begin
      FrameData   <= '0;
      ColSelect   <= '0;
      FrameStrobe <= '0;
      Configured  <= 1'b0;
      Error       <= 1'b0;
      frame_ptr   <= '0;
      remaining   <= '0;
    end else begin
      // Decoder output is zero outside STROBE, so the pulse self-clears.
      FrameStrobe <= strobe_onehot;

      if (data_load) FrameData <= wr.WriteData;

      if (hdr_end) begin
        Configured <= 1'b1;
        ColSelect  <= '0;
      end else if (hdr_load) begin
        ColSelect  <= col_onehot;
      end

      if (ptr_load) begin
        frame_ptr <= hdr.frame;
        remaining <= hdr.count;
      end else if (state_q == ST_STROBE) begin
        frame_ptr <= frame_ptr + 8'd1;
        remaining <= remaining - 16'd1;
      end

      if (hdr_err)      Error <= 1'b1;
      else if (err_clr) Error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_frame_config_loader.sv
// Self-checking bench for frame_config_loader: header vector table plus
// hand-written sequences, with a strobe scoreboard checked on the falling edge.
module tb_frame_config_loader;
  import frame_cfg_pkg::*;

  localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

  logic        CLK = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] FrameData;
  logic [15:0] ColSelect;
  logic [19:0] FrameStrobe;
  logic        Configured;
  logic        Error;

  frame_config_loader_if bus ();

  frame_config_loader dut (
    .CLK        (CLK),
    .resetn     (resetn),
    .wr         (bus),
    .FrameData  (FrameData),
    .ColSelect  (ColSelect),
    .FrameStrobe(FrameStrobe),
    .Configured (Configured),
    .Error      (Error)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [19:0] strobe;
    logic [31:0] data;
    logic [15:0] col;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [31:0] hdr;
    logic [31:0] data;
    logic [15:0] col;
    logic [19:0] strobe;
    logic        err;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Strobe monitor: every pulse must match the next scoreboard entry.
  logic prev_strobe = 1'b0;
  always @(negedge CLK) begin
    if (FrameStrobe != '0) begin
      if (prev_strobe) begin
        n_vec++; n_err++;
        $display("FAIL strobe_consecutive: got %0h at cycle %0d", FrameStrobe, cyc);
      end
      if (sb.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_strobe: got %0h expected none", FrameStrobe);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("strobe_bits", 64'(FrameStrobe), 64'(e.strobe));
        check("strobe_data", 64'(FrameData), 64'(e.data));
        check("strobe_col", 64'(ColSelect), 64'(e.col));
        check("strobe_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    prev_strobe = (FrameStrobe != '0);
  end

  task automatic send_word(input logic [31:0] w);
    int guard = 0;
    while (!bus.WriteReady && guard < 50) begin
      @(posedge CLK); #1;
      guard++;
    end
    if (guard >= 50) begin
      n_vec++; n_err++;
      $display("FAIL ready_timeout: got 0 expected 1");
    end
    bus.WriteData   = w;
    bus.WriteStrobe = 1'b1;
    @(posedge CLK); #1;
    bus.WriteStrobe = 1'b0;
  endtask

  // Data word whose strobe is expected in the cycle after the next edge.
  task automatic send_data(input logic [31:0] w, input logic [19:0] strobe, input logic [15:0] col);
    exp_t e;
    send_word(w);
    e.strobe = strobe; e.data = w; e.col = col; e.cyc = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic drain();
    int guard = 0;
    while (sb.size() != 0 && guard < 20) begin
      @(posedge CLK); #1;
      guard++;
    end
    if (sb.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL strobe_missing: got none expected %0d pending", sb.size());
      sb.delete();
    end
    idle(2);
  endtask

  task automatic do_reset();
    resetn          = 1'b0;
    bus.WriteStrobe = 1'b0;
    bus.WriteData   = '0;
    idle(2);
    resetn = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] g;

    vecs[0] = '{32'h0203_0001, 32'h1111_1111, 16'h0004, 20'h00008, 1'b0};
    vecs[1] = '{32'h0F13_0001, 32'hDEAD_BEEF, 16'h8000, 20'h80000, 1'b0};
    vecs[2] = '{32'h0000_0001, 32'h0000_0001, 16'h0001, 20'h00001, 1'b0};
    vecs[3] = '{32'h0012_0003, 32'h2222_2222, 16'h0000, 20'h00000, 1'b1};
    vecs[4] = '{32'h1000_0001, 32'h3333_3333, 16'h0000, 20'h00000, 1'b1};
    vecs[5] = '{32'h0013_0002, 32'h4444_4444, 16'h0000, 20'h00000, 1'b1};
    vecs[6] = '{32'h05FF_FFFF, 32'h5555_5555, 16'h0000, 20'h00000, 1'b1};

    bus.WriteStrobe = 1'b0;
    bus.WriteData   = '0;
    @(posedge CLK); #1;
    do_reset();

    check("rst_framedata", 64'(FrameData), 64'h0);
    check("rst_colselect", 64'(ColSelect), 64'h0);
    check("rst_strobe", 64'(FrameStrobe), 64'h0);
    check("rst_configured", 64'(Configured), 64'h0);
    check("rst_error", 64'(Error), 64'h0);
    check("rst_ready", 64'(bus.WriteReady), 64'h1);

    // Header table: legal single-frame loads and illegal headers.
    for (int i = 0; i < 7; i++) begin
      do_reset();
      send_word(SYNC);
      send_word(vecs[i].hdr);
      check($sformatf("vec%0d_error", i), 64'(Error), 64'(vecs[i].err));
      check($sformatf("vec%0d_col", i), 64'(ColSelect), 64'(vecs[i].col));
      if (vecs[i].err) begin
        send_word(vecs[i].data);
        check($sformatf("vec%0d_error_held", i), 64'(Error), 64'h1);
        send_word(SYNC);
        check($sformatf("vec%0d_error_clr", i), 64'(Error), 64'h0);
      end else begin
        send_data(vecs[i].data, vecs[i].strobe, vecs[i].col);
      end
      drain();
    end

    // Basic two-frame load followed by end-of-stream.
    do_reset();
    send_word(SYNC);
    send_word(32'h0203_0002);
    check("basic_col", 64'(ColSelect), 64'h0004);
    send_data(32'hA5A5_A5A5, 20'h00008, 16'h0004);
    send_data(32'h5A5A_5A5A, 20'h00010, 16'h0004);
    send_word(32'hFF00_0000);
    check("basic_configured", 64'(Configured), 64'h1);
    check("basic_col_clear", 64'(ColSelect), 64'h0);
    check("basic_idle", 64'(dut.state_q), 64'(ST_IDLE));
    drain();

    // Pre-sync garbage is discarded, including header/data lookalikes.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      g = $urandom();
      if (g == SYNC) g = g ^ 32'h1;
      send_word(g);
    end
    send_word(32'h0301_0001);
    send_word(32'h7777_7777);
    check("garbage_col", 64'(ColSelect), 64'h0);
    send_word(SYNC);
    send_word(32'h0301_0001);
    send_data(32'h1234_5678, 20'h00002, 16'h0008);
    drain();

    // Throughput: ready drops for exactly the strobe cycle, then returns.
    do_reset();
    send_word(SYNC);
    send_word(32'h0400_0004);
    for (int i = 0; i < 4; i++) begin
      send_data(32'hB000_0000 + 32'(i), 20'(1) << i, 16'h0010);
      check($sformatf("tput_ready_low%0d", i), 64'(bus.WriteReady), 64'h0);
      idle(1);
      check($sformatf("tput_ready_high%0d", i), 64'(bus.WriteReady), 64'h1);
    end
    // Backpressure: idle gap mid-frame holds FrameData with no extra strobe.
    send_word(32'h0400_0002);
    send_data(32'hCAFE_0001, 20'h00001, 16'h0010);
    idle(6);
    check("bp_data_held", 64'(FrameData), 64'hCAFE_0001);
    send_data(32'hCAFE_0002, 20'h00002, 16'h0010);
    drain();

    // Reset during the STROBE cycle drops the frame entirely.
    do_reset();
    send_word(SYNC);
    send_word(32'h0200_0001);
    send_word(32'h9999_9999);
    check("midrst_in_strobe", 64'(bus.WriteReady), 64'h0);
    resetn = 1'b0;
    @(posedge CLK); #1;
    check("midrst_strobe", 64'(FrameStrobe), 64'h0);
    check("midrst_data", 64'(FrameData), 64'h0);
    check("midrst_col", 64'(ColSelect), 64'h0);
    check("midrst_ready", 64'(bus.WriteReady), 64'h1);
    resetn = 1'b1;
    send_word(32'h0200_0001);
    send_word(32'h8888_8888);
    check("midrst_nosync_col", 64'(ColSelect), 64'h0);
    idle(4);

    // Zero-count header only moves the column select.
    do_reset();
    send_word(SYNC);
    send_word(32'h0105_0000);
    check("zero_col", 64'(ColSelect), 64'h0002);
    send_word(32'h0100_0001);
    send_data(32'h0BAD_F00D, 20'h00001, 16'h0002);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/frame_config_loader.md
# frame_config_loader

Configuration-side writer for the frame-based fabric configuration. It accepts a word stream of 32-bit configuration words and parses sync, header and data words. It drives `FrameData` plus a one-hot column select and a one-hot `FrameStrobe` pulse into the tile configuration latches, which in turn feed the `ConfigBits` of LUT/mux BELs. It sits between the bitstream source (UART or host bridge) and the fabric column frame registers.

## Interface
Parameters:
- `FRAME_BITS`, 32: width of one configuration frame word; must be 32.
- `FRAMES_PER_COL`, 20: frames per column; valid frame indices are 0..FRAMES_PER_COL-1.
- `NUM_COLS`, 16: number of fabric columns; valid column indices are 0..NUM_COLS-1.
- `SYNC_WORD`, 32'hFAB0_FAB1: stream synchronisation word.

Ports:
- `CLK` in 1: configuration clock; all logic is on the rising edge.
- `resetn` in 1: reset, **synchronous and active-low**. Only one clock is used.
- `WriteData` in 32: incoming stream word.
- `WriteStrobe` in 1: word valid. A word is accepted when `WriteStrobe & WriteReady` is high at a rising edge.
- `WriteReady` out 1: loader can accept a word.
- `FrameData` out FRAME_BITS: frame payload to the column latches.
- `ColSelect` out NUM_COLS: one-hot column select; held stable for the whole block.
- `FrameStrobe` out FRAMES_PER_COL: one-hot, single-cycle latch pulse.
- `Configured` out 1: sticky flag, set when the end-of-stream header is accepted.
- `Error` out 1: sticky flag, set on an illegal header.

## Operation
State machine states: IDLE, HEADER, DATA, STROBE, ERROR.

Reset values: all outputs are 0 except `WriteReady`, which is 1. The state resets to IDLE.

Behaviour per state:
- IDLE: `WriteReady`=1. Non-sync words are discarded. `SYNC_WORD` moves to HEADER and clears `Error`.
- HEADER: `WriteReady`=1. The header word fields are:
  - `col` = [31:24]
  - `frame` = [23:16]
  - `count` = [15:0]
- Header handling in HEADER, in order of precedence:
  - `col`==8'hFF (end-of-stream): set `Configured`, clear `ColSelect`, go to IDLE.
  - `col`>=NUM_COLS, or `frame`+`count` > FRAMES_PER_COL (computed at 17-bit width, no wrap): go to ERROR and set `Error`.
  - `count`==0: update `ColSelect`, stay in HEADER.
  - Otherwise: `ColSelect`<=onehot(`col`), load the frame pointer with `frame` and the remaining counter with `count`, go to DATA.
- DATA: `WriteReady`=1. An accepted word does `FrameData`<=`WriteData` and goes to STROBE.
- STROBE: `WriteReady`=0. At the edge ending this cycle:
  - `FrameStrobe`<=onehot(pointer);
  - pointer+1 and remaining-1;
  - if remaining was 1, go to HEADER, else go to DATA.
- `FrameStrobe` returns to 0 at the next edge unconditionally.
- ERROR: `WriteReady`=1. All words are discarded except `SYNC_WORD`, which goes to HEADER. `Error` stays set until that resync.
- `SYNC_WORD` received in HEADER or DATA is treated as ordinary data or header content; it gets no special meaning.
- `Configured` is cleared only by reset.

## Timing
- Data word accepted at edge t:
  - `FrameData` is valid from cycle t+1.
  - `WriteReady`=0 during cycle t+1.
  - `FrameStrobe` is high for exactly cycle t+2.
  - `WriteReady`=1 again in cycle t+2.
  - The next word can be accepted at edge t+2, so `FrameData` changes no earlier than t+3.
- `FrameData` is therefore stable one full cycle before and during the strobe.
- Maximum throughput is one data word per 2 cycles. Header and sync words take 1 cycle each.
- `ColSelect` changes only on a header accept. It is constant through all strobes of that header.
- At most one `FrameStrobe` bit is high in any cycle, and never two consecutive cycles.
- `WriteStrobe` low in DATA causes the loader to wait indefinitely. There is no timeout.
- Reset asserted mid-operation (including the STROBE cycle): at the next edge all outputs return to reset values, no strobe is issued, and the partial frame is dropped.

## Structure
- Package `frame_cfg_pkg` holds:
  - the state enum;
  - the `END_COL` constant, 8'hFF;
  - header field bit positions;
  - the default `SYNC_WORD`.
- Sub-module `frame_onehot_dec`: parameterised binary-to-one-hot decoder with an enable input. It is instantiated twice: for `ColSelect` (enable = header accept) and for `FrameStrobe` (enable = STROBE state).

## Test plan
- Basic load: SYNC, header 32'h0203_0002, data A5A5A5A5 then 5A5A5A5A, header 32'hFF00_0000.
  - `ColSelect`=16'h0004.
  - `FrameStrobe`=bit3 with `FrameData`=A5A5A5A5, then bit4 with `FrameData`=5A5A5A5A.
  - `Configured`=1; final state IDLE.
- Pre-sync garbage: 3 random words, then SYNC, header, 1 data word. No strobe occurs before the sync; exactly one strobe occurs after it.
- Bounds check:
  - header 32'h0012_0003 (frame 18 + count 3 = 21 > 20) -> `Error`=1, no strobe. Following data words are ignored until SYNC, which clears `Error`.
  - header 32'h1000_0001 (col 16) -> `Error`=1.
- Throughput and backpressure: data presented every cycle -> `WriteReady` toggles 1/0 and strobes are 2 cycles apart. With 5 idle cycles inserted mid-frame, `FrameData` is held and no extra strobe occurs.
- Reset mid-frame: drop `resetn` in the STROBE cycle -> no `FrameStrobe` pulse, all outputs 0, `WriteReady`=1. After release, a new SYNC is required before a header is accepted.
- Zero-count header: header 32'h0105_0000 then header 32'h0100_0001 with 1 data word -> `ColSelect`=bit1 and a single strobe on bit0.
